spi_controller: RTL and testbench



---
 rtl/spi_controller.sv | 181 ++++++++++++++++++
 tb/tb_spi_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 frame controller: sends one 16-bit {rw, addr[6:0], data[7:0]} frame MSB first.
// Optional capture of cipo on data bits 7..0 into rdata when SPI_CTRL_READBACK_EN is defined.
module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
`ifdef SPI_CTRL_READBACK_EN
    input  logic       cipo,
    output logic [7:0] rdata,
`endif
    output logic       busy,
    output logic       done,
    output logic       cs_n,
    output logic       sclk,
    output logic       copi
);

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ph_q, ph_d;
    logic [3:0]        bit_q, bit_d;
    logic [15:0]       shreg_q, shreg_d;
    logic              done_q, done_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              copi_q, copi_d;
    logic              phase_end;
    logic              hi_end;

    assign phase_end = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign hi_end    = (state_q == SHIFT) && ph_q && phase_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        ph_d    = ph_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                copi_d = 1'b0;
                if (start) begin
                    shreg_d = {rw, addr, wdata};
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    copi_d  = shreg_d[15];
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    ph_d    = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                copi_d = shreg_q[15];
                if (phase_end) begin
                    cnt_d = '0;
                    if (!ph_q) begin
                        ph_d   = 1'b1;
                        sclk_d = 1'b1;
                    end else begin
                        // Falling sclk and the next copi bit leave the flops together.
                        ph_d    = 1'b0;
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[14:0], 1'b0};
                        bit_d   = bit_q + 4'd1;
                        copi_d  = shreg_d[15];
                        if (bit_q == 4'd15) begin
                            state_d = HOLD;
                            copi_d  = 1'b0;
                        end
                    end
                end
            end
            HOLD: begin
                copi_d = 1'b0;
                if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                    cnt_d   = '0;
                    state_d = GAP;
                    cs_n_d  = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ph_q    <= 1'b0;
            bit_q   <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign cs_n = cs_n_q;
    assign sclk = sclk_q;
    assign copi = copi_q;

`ifdef SPI_CTRL_READBACK_EN
    logic       cipo_s1_q, cipo_s2_q;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] rdata_q, rdata_d;

    // Frame bits 7..0 are bit counter values 8..15, hence bit_q[3].
    always_comb begin
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        if (hi_end && bit_q[3]) shadow_d = {shadow_q[6:0], cipo_s2_q};
        if (done_d) rdata_d = shadow_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cipo_s1_q <= 1'b0;
            cipo_s2_q <= 1'b0;
            shadow_q  <= '0;
            rdata_q   <= '0;
        end else begin
            cipo_s1_q <= cipo;
            cipo_s2_q <= cipo_s1_q;
            shadow_q  <= shadow_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata = rdata_q;
`else
    logic unused_hi_end;
    assign unused_hi_end = hi_end;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: scoreboard of transmitted frames plus a small register-file peripheral model.
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst, start, rw, start_f;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy, done, cs_n, sclk, copi;
    logic       busy_f, done_f, cs_n_f, sclk_f, copi_f;
`ifdef SPI_CTRL_READBACK_EN
    logic       cipo;
    logic       cipo_f = 1'b0;
    logic [7:0] rdata, rdata_f;
    logic [7:0] rb_val = 8'h00;
`endif

    always #5 clk = ~clk;

    spi_controller dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
`ifdef SPI_CTRL_READBACK_EN
        .cipo(cipo), .rdata(rdata),
`endif
        .busy(busy), .done(done), .cs_n(cs_n), .sclk(sclk), .copi(copi)
    );

    spi_controller #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut_f (
        .clk(clk), .rst(rst), .start(start_f), .rw(rw), .addr(addr), .wdata(wdata),
`ifdef SPI_CTRL_READBACK_EN
        .cipo(cipo_f), .rdata(rdata_f),
`endif
        .busy(busy_f), .done(done_f), .cs_n(cs_n_f), .sclk(sclk_f), .copi(copi_f)
    );

    int errors = 0;
    int checks = 0;
    int cyc;
    int rises = 0;
    int falls = 0;
    int trunc = 0;
    int hi_run = 0;
    int last_gap = 0;
    logic [15:0] shin = '0;
    logic [15:0] exp_q[$];
    logic [7:0]  regs[0:4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Peripheral side: capture copi on sclk rises, commit a complete frame when cs_n rises.
    always @(negedge cs_n) begin
        rises = 0;
        falls = 0;
        shin  = '0;
    end
    always @(posedge sclk) begin
        shin = {shin[14:0], copi};
        rises++;
    end
    always @(negedge sclk) falls++;
    always @(posedge cs_n) begin
        if (rises == 16) begin
            if (exp_q.size() == 0) check("unexpected_frame", shin, 16'hxxxx);
            else check("frame_bits", shin, exp_q.pop_front());
            if (shin[15] && shin[14:8] < 7'd5) regs[shin[10:8]] = shin[7:0];
        end else if (rises != 0) begin
            trunc++;
        end
    end

`ifdef SPI_CTRL_READBACK_EN
    assign cipo = (falls >= 8 && falls < 16) ? rb_val[3'(15 - falls)] : 1'b0;
`endif

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("sclk_while_cs_high", {31'd0, cs_n === 1'b1 && sclk === 1'b1}, 32'd0);
            if (cs_n === 1'b1) hi_run++;
            else begin
                if (hi_run > 0) last_gap = hi_run;
                hi_run = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_frame(input logic r, input logic [6:0] a, input logic [7:0] d, input bit keep);
        @(negedge clk);
        rw = r; addr = a; wdata = d; start = 1'b1;
        exp_q.push_back({r, a, d});
        @(posedge clk);
        #1;
        if (!keep) start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input int exp, input string tag);
        while (done !== 1'b1 && cyc < 600) step();
        check(tag, cyc, exp);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    int low_cnt, run, hmin, hmax, nrise;
    bit done_seen;

    initial begin
        for (int i = 0; i < 5; i++) regs[i] = 8'h00;
        rst = 1'b1; start = 1'b0; start_f = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_copi", {31'd0, copi}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
`ifdef SPI_CTRL_READBACK_EN
        check("rst_rdata", {24'd0, rdata}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Write reg_0.
        begin_frame(1'b1, 7'h00, 8'hF0, 1'b0);
        check("setup_cs_n", {31'd0, cs_n}, 32'd0);
        check("setup_copi", {31'd0, copi}, 32'd1);
        wait_done(137, "w0_done_lat");
        step();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("reg0", {24'd0, regs[0]}, 32'h0F0);

        // Start while busy is ignored.
        begin_frame(1'b1, 7'h01, 8'h11, 1'b0);
        while (cyc < 10) step();
        addr = 7'h02; wdata = 8'hEE; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(137, "busy_done_lat");
        repeat (20) step();
        check("reg1_busy_test", {24'd0, regs[1]}, 32'h11);
        check("reg2_untouched", {24'd0, regs[2]}, 32'h0);
        check("busy_no_extra", {31'd0, busy}, 32'd0);

        // Back-to-back frames with start held high.
        begin_frame(1'b1, 7'h03, 8'hA5, 1'b1);
        wait_done(137, "b2b1_done_lat");
        addr = 7'h04; wdata = 8'h5A;
        exp_q.push_back({1'b1, 7'h04, 8'h5A});
        step();
        start = 1'b0;
        cyc = 1;
        check("b2b_second_busy", {31'd0, busy}, 32'd1);
        wait_done(137, "b2b2_done_lat");
        check("b2b_gap_min", {31'd0, last_gap >= 4}, 32'd1);
        check("reg3", {24'd0, regs[3]}, 32'hA5);
        check("reg4", {24'd0, regs[4]}, 32'h5A);

        // Out-of-range address still goes out verbatim.
        begin_frame(1'b1, 7'h55, 8'h3C, 1'b0);
        wait_done(137, "oor_done_lat");

        // Reset at the 7th sclk rise.
        begin_frame(1'b1, 7'h02, 8'h99, 1'b0);
        while (rises < 7 && cyc < 600) step();
        check("rise7_reached", rises, 7);
        rst = 1'b1;
        step();
        check("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("mid_rst_sclk", {31'd0, sclk}, 32'd0);
        check("mid_rst_copi", {31'd0, copi}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        void'(exp_q.pop_back());
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (150) begin
            step();
            if (done === 1'b1) done_seen = 1'b1;
        end
        check("mid_rst_no_done", {31'd0, done_seen}, 32'd0);
        check("trunc_frames", trunc, 1);
        check("reg2_after_abort", {24'd0, regs[2]}, 32'h0);
        begin_frame(1'b1, 7'h01, 8'h77, 1'b0);
        wait_done(137, "post_rst_done_lat");
        check("reg1_post_rst", {24'd0, regs[1]}, 32'h77);

`ifdef SPI_CTRL_READBACK_EN
        rb_val = 8'h3C;
        begin_frame(1'b0, 7'h01, 8'h00, 1'b0);
        wait_done(137, "rd_done_lat");
        check("rdata_done", {24'd0, rdata}, 32'h3C);
        rb_val = 8'hC3;
        begin_frame(1'b0, 7'h01, 8'h00, 1'b0);
        while (cyc < 120) step();
        check("rdata_hold", {24'd0, rdata}, 32'h3C);
        wait_done(137, "rd2_done_lat");
        check("rdata_next", {24'd0, rdata}, 32'hC3);
        check("reg1_after_read", {24'd0, regs[1]}, 32'h77);
`endif

        // Fast-parameter instance framing.
        @(negedge clk);
        rw = 1'b1; addr = 7'h02; wdata = 8'h81; start_f = 1'b1;
        @(posedge clk);
        #1;
        start_f = 1'b0;
        cyc = 1; low_cnt = 0; run = 0; hmin = 1000; hmax = 0; nrise = 0;
        while (done_f !== 1'b1 && cyc < 300) begin
            if (cs_n_f === 1'b0) low_cnt++;
            if (sclk_f === 1'b1) begin
                if (run == 0) nrise++;
                run++;
            end else if (run > 0) begin
                if (run < hmin) hmin = run;
                if (run > hmax) hmax = run;
                run = 0;
            end
            step();
        end
        check("fast_done_lat", cyc, 68);
        check("fast_cs_low", low_cnt, 66);
        check("fast_rises", nrise, 16);
        check("fast_high_min", hmin, 2);
        check("fast_high_max", hmax, 2);
        check("fast_busy_done", {31'd0, busy_f}, 32'd0);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
